burst_ram_arbiter: RTL and testbench

Shares the single BurstRAM port between two burst requesters: port 0 is the instruction cache (line fills) and port 1 is the data cache (fills and write-backs). Arbitration is round-robin, one whole burst per grant. The arbiter owns the BurstRAM command handshake, routes write beats from the owner to the RAM, and steers read beats back to the owner. It sits between the cache modules and BurstRAM, on the same clk and rst as both.

---
 rtl/burst_ram_arbiter_pkg.sv | 22 ++
 rtl/burst_ram_arbiter_rr_arbiter2.sv | 26 ++
 rtl/burst_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// ============================================================================
// burst_ram_arbiter_pkg : command codes and FSM state encoding for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package burst_ram_arbiter_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/burst_ram_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-input round-robin pick; on a tie the non-last owner wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_valid,
    output logic       o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~i_last_owner;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/burst_ram_arbiter.sv
// ============================================================================
// burst_ram_arbiter : shares one BurstRAM port between I-cache (p0) and
//                     D-cache (p1), one whole burst per round-robin grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   p0_req,
    input  logic                                   p0_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          p0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p0_data_mask,
    output logic                                   p0_wr_beat,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_rd_data,
    output logic                                   p0_rd_data_valid,
    output logic                                   p0_done,

    input  logic                                   p1_req,
    input  logic                                   p1_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          p1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p1_data_mask,
    output logic                                   p1_wr_beat,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_rd_data,
    output logic                                   p1_rd_data_valid,
    output logic                                   p1_done,

    output logic                                   br_cmd,
    output logic                                   br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                                   br_rd_data_valid,
    input  logic                                   br_busy
);

    localparam int              CNT_W     = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    state_t                        r_state;
    logic                          r_owner;
    logic                          r_last_owner;
    logic                          r_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_addr;
    logic [CNT_W-1:0]              r_beat;

    logic                          w_grant_valid;
    logic                          w_grant;
    logic                          w_wr_phase;
    logic                          w_rd_phase;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req        ({p1_req, p0_req}),
        .i_last_owner (r_last_owner),
        .o_valid      (w_grant_valid),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cmd        <= CMD_READ;
            r_addr       <= '0;
            r_beat       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!br_busy && w_grant_valid) begin
                        r_owner <= w_grant;
                        r_cmd   <= w_grant ? p1_cmd  : p0_cmd;
                        r_addr  <= w_grant ? p1_addr : p0_addr;
                        r_beat  <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A write's first beat rides along with the command cycle
                    if (r_cmd == CMD_READ) begin
                        r_state <= ST_READ;
                    end else begin
                        r_beat  <= r_beat + CNT_W'(1);
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_beat <= r_beat + CNT_W'(1);
                    if (r_beat == LAST_BEAT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_READ: begin
                    if (br_rd_data_valid) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state/owner only, so req never reaches them
    assign w_wr_phase = (r_cmd == CMD_WRITE) && ((r_state == ST_ISSUE) || (r_state == ST_WRITE));
    assign w_rd_phase = (r_state == ST_READ);

    assign br_cmd_en    = (r_state == ST_ISSUE);
    assign br_cmd       = br_cmd_en & r_cmd;
    assign br_addr      = br_cmd_en ? r_addr : '0;
    assign br_wr_data   = w_wr_phase ? (r_owner ? p1_wr_data   : p0_wr_data)   : '0;
    assign br_data_mask = w_wr_phase ? (r_owner ? p1_data_mask : p0_data_mask) : '0;

    assign p0_wr_beat       = w_wr_phase && !r_owner;
    assign p1_wr_beat       = w_wr_phase &&  r_owner;
    assign p0_rd_data       = br_rd_data;
    assign p1_rd_data       = br_rd_data;
    assign p0_rd_data_valid = br_rd_data_valid && w_rd_phase && !r_owner;
    assign p1_rd_data_valid = br_rd_data_valid && w_rd_phase &&  r_owner;
    assign p0_done          = (r_state == ST_DONE) && !r_owner;
    assign p1_done          = (r_state == ST_DONE) &&  r_owner;

endmodule

`default_nettype wire

// File: tb/tb_burst_ram_arbiter.sv
// ============================================================================
// tb_burst_ram_arbiter : randomized scenarios against a burst-timeline model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_burst_ram_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 64;
    localparam int CNT = 4;
    localparam int MW  = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_cmd, p1_req, p1_cmd;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wr_data, p1_wr_data;
    logic [MW-1:0] p0_data_mask, p1_data_mask;
    logic          p0_wr_beat, p0_rd_data_valid, p0_done;
    logic          p1_wr_beat, p1_rd_data_valid, p1_done;
    logic [DW-1:0] p0_rd_data, p1_rd_data;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [DW-1:0] br_rd_data;
    logic          br_rd_data_valid, br_busy;

    always #5 clk = ~clk;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH      (AW),
        .RAM_BURST_DATA_BITWIDTH (DW),
        .RAM_BURST_DATA_COUNT    (CNT)
    ) dut (
        .clk (clk), .rst (rst),
        .p0_req (p0_req), .p0_cmd (p0_cmd), .p0_addr (p0_addr),
        .p0_wr_data (p0_wr_data), .p0_data_mask (p0_data_mask),
        .p0_wr_beat (p0_wr_beat), .p0_rd_data (p0_rd_data),
        .p0_rd_data_valid (p0_rd_data_valid), .p0_done (p0_done),
        .p1_req (p1_req), .p1_cmd (p1_cmd), .p1_addr (p1_addr),
        .p1_wr_data (p1_wr_data), .p1_data_mask (p1_data_mask),
        .p1_wr_beat (p1_wr_beat), .p1_rd_data (p1_rd_data),
        .p1_rd_data_valid (p1_rd_data_valid), .p1_done (p1_done),
        .br_cmd (br_cmd), .br_cmd_en (br_cmd_en), .br_addr (br_addr),
        .br_wr_data (br_wr_data), .br_data_mask (br_data_mask),
        .br_rd_data (br_rd_data), .br_rd_data_valid (br_rd_data_valid),
        .br_busy (br_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scenario plan: what each requester wants and how the RAM answers
    logic          pl_act   [2];
    logic          pl_cmd   [2];
    logic [AW-1:0] pl_addr  [2];
    int            pl_req_at[2];
    int            pl_lat   [2];
    logic [DW-1:0] pl_wd    [2][CNT];
    logic [MW-1:0] pl_wm    [2][CNT];
    logic [DW-1:0] pl_rd    [2][CNT];
    int            busy_until;
    bit            stray_en;
    logic          m_last;

    task automatic clear_plan();
        pl_act[0] = 1'b0;
        pl_act[1] = 1'b0;
        busy_until = 0;
        stray_en   = 1'b0;
    endtask

    task automatic plan_port(input int p, input logic cmd, input logic [AW-1:0] addr,
                             input int req_at, input int lat);
        pl_act[p]    = 1'b1;
        pl_cmd[p]    = cmd;
        pl_addr[p]   = addr;
        pl_req_at[p] = req_at;
        pl_lat[p]    = lat;
        for (int j = 0; j < CNT; j++) begin
            pl_wd[p][j] = {$urandom, $urandom};
            pl_wm[p][j] = MW'($urandom);
            pl_rd[p][j] = {$urandom, $urandom};
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        br_rd_data_valid = 1'b0; br_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1'b1;
    endtask

    // Runs the current plan cycle by cycle; the expected timeline comes from
    // the burst rules: grant in an eligible IDLE cycle, command the cycle after,
    // COUNT write beats from the command cycle, done one cycle after the last beat.
    task automatic run_session(input string name, input int budget);
        int cur, issue, done_at, free_at, t, c, widx0, widx1, rj;
        int rd_at [CNT];
        bit fin [2];
        bit rq [2];
        bit all_done, in_read, rv;
        logic exp_en, exp_wb0, exp_wb1, exp_rv0, exp_rv1, exp_dn0, exp_dn1;
        logic [DW-1:0] exp_wd;
        logic [MW-1:0] exp_wm;
        cur = -1; issue = 0; done_at = 0; free_at = 0; t = 0; rj = 0;
        fin[0] = 1'b0; fin[1] = 1'b0; all_done = 1'b0;
        for (int j = 0; j < CNT; j++) rd_at[j] = -1;
        while (!all_done && t < budget) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) rq[p] = pl_act[p] && (t >= pl_req_at[p]) && !fin[p];
            if (cur < 0 && t >= free_at && t >= busy_until && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) cur = m_last ? 0 : 1;
                else                cur = rq[1] ? 1 : 0;
                issue = t + 1;
                if (pl_cmd[cur]) begin
                    done_at = issue + CNT;
                end else begin
                    c = issue + pl_lat[cur];
                    for (int j = 0; j < CNT; j++) begin
                        rd_at[j] = c;
                        c = c + 1 + int'($urandom_range(0, 1));
                    end
                    done_at = rd_at[CNT-1] + 1;
                end
            end
            widx0 = 0; widx1 = 0;
            if (cur >= 0 && pl_cmd[cur] && t >= issue) begin
                if (cur == 0) widx0 = (t - issue < CNT) ? t - issue : CNT - 1;
                else          widx1 = (t - issue < CNT) ? t - issue : CNT - 1;
            end
            p0_req = rq[0]; p0_cmd = pl_cmd[0]; p0_addr = pl_addr[0];
            p0_wr_data = pl_wd[0][widx0]; p0_data_mask = pl_wm[0][widx0];
            p1_req = rq[1]; p1_cmd = pl_cmd[1]; p1_addr = pl_addr[1];
            p1_wr_data = pl_wd[1][widx1]; p1_data_mask = pl_wm[1][widx1];
            br_busy = (t < busy_until);
            in_read = 1'b0;
            if (cur >= 0) in_read = !pl_cmd[cur] && (t > issue) && (t < done_at);
            rv = 1'b0;
            br_rd_data = {$urandom, $urandom};
            if (in_read) begin
                for (int j = 0; j < CNT; j++) if (rd_at[j] == t) begin rv = 1'b1; rj = j; end
                if (rv) br_rd_data = pl_rd[cur][rj];
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                rv = 1'b1;
            end
            br_rd_data_valid = rv;
            #1;
            exp_en = (cur >= 0) && (t == issue);
            exp_wb0 = 0; exp_wb1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_dn0 = 0; exp_dn1 = 0;
            exp_wd = '0; exp_wm = '0;
            if (cur >= 0) begin
                if (pl_cmd[cur] && t >= issue && t < issue + CNT) begin
                    if (cur == 0) exp_wb0 = 1'b1; else exp_wb1 = 1'b1;
                    exp_wd = pl_wd[cur][t - issue];
                    exp_wm = pl_wm[cur][t - issue];
                end
                if (in_read && rv) begin
                    if (cur == 0) exp_rv0 = 1'b1; else exp_rv1 = 1'b1;
                end
                if (t == done_at) begin
                    if (cur == 0) exp_dn0 = 1'b1; else exp_dn1 = 1'b1;
                end
            end
            n_cmp++;
            if (br_cmd_en !== exp_en) begin
                n_fail++; $display("FAIL %s cmd_en t=%0d: got %b expected %b", name, t, br_cmd_en, exp_en);
            end
            if (exp_en) begin
                n_cmp++;
                if (br_cmd !== pl_cmd[cur] || br_addr !== pl_addr[cur]) begin
                    n_fail++; $display("FAIL %s cmd/addr t=%0d: got %b/%h expected %b/%h",
                                       name, t, br_cmd, br_addr, pl_cmd[cur], pl_addr[cur]);
                end
            end
            n_cmp++;
            if ({p0_wr_beat, p1_wr_beat} !== {exp_wb0, exp_wb1}) begin
                n_fail++; $display("FAIL %s wr_beat t=%0d: got %b%b expected %b%b",
                                   name, t, p0_wr_beat, p1_wr_beat, exp_wb0, exp_wb1);
            end
            n_cmp++;
            if (br_wr_data !== exp_wd || br_data_mask !== exp_wm) begin
                n_fail++; $display("FAIL %s wr_data t=%0d: got %h/%h expected %h/%h",
                                   name, t, br_wr_data, br_data_mask, exp_wd, exp_wm);
            end
            n_cmp++;
            if ({p0_rd_data_valid, p1_rd_data_valid} !== {exp_rv0, exp_rv1}) begin
                n_fail++; $display("FAIL %s rd_valid t=%0d: got %b%b expected %b%b",
                                   name, t, p0_rd_data_valid, p1_rd_data_valid, exp_rv0, exp_rv1);
            end
            if (exp_rv0 || exp_rv1) begin
                n_cmp++;
                if ((exp_rv0 ? p0_rd_data : p1_rd_data) !== pl_rd[cur][rj]) begin
                    n_fail++; $display("FAIL %s rd_data t=%0d: got %h expected %h", name, t,
                                       exp_rv0 ? p0_rd_data : p1_rd_data, pl_rd[cur][rj]);
                end
            end
            n_cmp++;
            if ({p0_done, p1_done} !== {exp_dn0, exp_dn1}) begin
                n_fail++; $display("FAIL %s done t=%0d: got %b%b expected %b%b",
                                   name, t, p0_done, p1_done, exp_dn0, exp_dn1);
            end
            if (cur >= 0 && t == done_at) begin
                fin[cur] = 1'b1;
                m_last   = (cur == 1);
                cur      = -1;
                free_at  = t + 1;
            end
            all_done = (!pl_act[0] || fin[0]) && (!pl_act[1] || fin[1]);
            t++;
        end
        p0_req = 1'b0; p1_req = 1'b0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
        if (!all_done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: got unfinished after %0d cycles expected completion", name, budget);
            hard_reset();
        end
    endtask

    task automatic test_reset();
        logic [83:0] outs;
        rst = 1'b1;
        p0_req = 0; p0_cmd = 0; p0_addr = '0; p0_wr_data = '0; p0_data_mask = '0;
        p1_req = 0; p1_cmd = 0; p1_addr = '0; p1_wr_data = '0; p1_data_mask = '0;
        br_rd_data = '0; br_rd_data_valid = 0; br_busy = 0;
        repeat (3) @(posedge clk);
        #1;
        outs = {br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                p0_wr_beat, p0_rd_data_valid, p0_done, p1_wr_beat, p1_rd_data_valid, p1_done};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_read_port0();
        clear_plan();
        plan_port(0, 1'b0, 4'd3, 0, 2);
        run_session("read_p0", 200);
    endtask

    task automatic test_write_port1();
        clear_plan();
        plan_port(1, 1'b1, 4'd5, 0, 1);
        for (int j = 0; j < CNT; j++) pl_wm[1][j] = 8'hFF;
        run_session("write_p1", 200);
    endtask

    task automatic test_tie();
        hard_reset();
        clear_plan();
        plan_port(0, 1'($urandom), 4'($urandom), 0, 1);
        plan_port(1, 1'($urandom), 4'($urandom), 0, 3);
        run_session("tie_after_reset", 300);
        clear_plan();
        plan_port(0, 1'b1, 4'd9, 0, 1);
        run_session("single_p0", 200);
        clear_plan();
        plan_port(0, 1'b0, 4'd1, 0, 2);
        plan_port(1, 1'b1, 4'd2, 0, 1);
        run_session("tie_repeat", 300);
    endtask

    task automatic test_busy();
        clear_plan();
        plan_port(0, 1'b0, 4'd7, 0, 1);
        busy_until = 10;
        run_session("busy_hold", 200);
    endtask

    task automatic test_reset_midburst();
        logic [DW-1:0] d [CNT];
        logic [83:0] outs;
        for (int j = 0; j < CNT; j++) d[j] = {$urandom, $urandom};
        p1_cmd = 1'b1; p1_addr = 4'd12; p1_data_mask = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            p1_req     = 1'b1;
            p1_wr_data = d[(t >= 1) ? t - 1 : 0];
            if (t == 3) rst = 1'b1;
            #1;
            if (t == 3) begin
                n_cmp++;
                if (p1_wr_beat !== 1'b1 || br_wr_data !== d[2]) begin
                    n_fail++; $display("FAIL midburst_beat2: got %b/%h expected 1/%h", p1_wr_beat, br_wr_data, d[2]);
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; p1_req = 1'b0;
        #1;
        outs = {br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                p0_wr_beat, p0_rd_data_valid, p0_done, p1_wr_beat, p1_rd_data_valid, p1_done};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL midburst_reset_outputs: got %h expected 0", outs);
        end
        m_last = 1'b1;
        clear_plan();
        plan_port(1, 1'b1, 4'd4, 0, 1);
        run_session("after_midburst_reset", 200);
    endtask

    task automatic test_idle_rdvalid();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            br_rd_data_valid = 1'b1;
            br_rd_data = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (p0_rd_data_valid !== 1'b0 || p1_rd_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_rd_valid: got %b%b expected 00", p0_rd_data_valid, p1_rd_data_valid);
            end
        end
        br_rd_data_valid = 1'b0;
    endtask

    task automatic test_random();
        int which;
        for (int s = 0; s < 12; s++) begin
            clear_plan();
            which = int'($urandom_range(1, 3));
            if (which[0]) plan_port(0, 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            if (which[1]) plan_port(1, 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            busy_until = int'($urandom_range(0, 3));
            stray_en   = 1'b1;
            run_session("random", 400);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_port0();
        test_write_port1();
        test_tie();
        test_busy();
        test_reset_midburst();
        test_idle_rdvalid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
